// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// instruction field positions, the NOP word and the default PC increment.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } if_state_t;

    localparam int REGD_MSB = 15;
    localparam int REGD_LSB = 13;
    localparam int REGA_MSB = 12;
    localparam int REGA_LSB = 10;
    localparam int REGB_MSB = 9;
    localparam int REGB_LSB = 7;
    localparam int CTRL_MSB = 6;
    localparam int CTRL_LSB = 0;

    localparam logic [15:0] NOP_INSTR       = 16'h0000;
    localparam logic [15:0] DEFAULT_PC_STEP = 16'd2;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register: async active-low reset to RESET_PC, a load port
// and an increment-by-PC_STEP port (load wins if both are asserted).
module program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] PC_STEP  = DEFAULT_PC_STEP,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        inc,
    output logic [15:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, memory read handshake and IR write strobe.
// Optional fetch timeout with FAULT state is enabled by defining IF_TIMEOUT_EN.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] PC_STEP        = DEFAULT_PC_STEP,
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        input_IF_start,
    input  logic        input_IF_pc_load,
    input  logic [15:0] input_IF_pc_value,
    output logic [15:0] Output_IF_mem_addr,
    output logic        Output_IF_mem_req,
    input  logic        input_IF_mem_ready,
    input  logic [15:0] input_IF_mem_data,
    output logic [15:0] Output_IF_Instru,
    output logic        Output_IF_IR_write,
    output logic [15:0] Output_IF_PC,
    output logic        Output_IF_busy,
    output logic        Output_IF_fault
);

    if_state_t   state, state_nxt;
    logic        pc_ld, pc_inc, capture;
    logic [15:0] pc;
    logic [15:0] instr_q;

`ifdef IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    program_counter #(
        .PC_STEP  (PC_STEP),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (CLK),
        .rst_n      (RST_n),
        .load       (pc_ld),
        .load_value (input_IF_pc_value),
        .inc        (pc_inc),
        .pc         (pc)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_ld     = 1'b0;
        pc_inc    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A same-cycle load lands at the REQ entry edge, so the fetch sees the new PC.
                pc_ld = input_IF_pc_load;
                if (input_IF_start) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (input_IF_mem_ready) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end
`ifdef IF_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    state_nxt = ST_FAULT;
                end
`endif
            end
            ST_DONE: begin
                pc_inc    = 1'b1;
                state_nxt = ST_IDLE;
            end
`ifdef IF_TIMEOUT_EN
            ST_FAULT: begin
                if (input_IF_pc_load) begin
                    pc_ld     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Output_IF_mem_req  = 1'b0;
        Output_IF_IR_write = 1'b0;
        Output_IF_busy     = 1'b0;
        Output_IF_fault    = 1'b0;
        case (state)
            ST_REQ: begin
                Output_IF_mem_req = 1'b1;
                Output_IF_busy    = 1'b1;
            end
            ST_DONE: begin
                Output_IF_IR_write = 1'b1;
                Output_IF_busy     = 1'b1;
            end
`ifdef IF_TIMEOUT_EN
            ST_FAULT: Output_IF_fault = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            instr_q <= NOP_INSTR;
        end else if (capture) begin
            instr_q <= input_IF_mem_data;
        end
    end

`ifdef IF_TIMEOUT_EN
    // Counts wait cycles of the current request; held at zero outside REQ.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wait_cnt <= '0;
        end else if (state != ST_REQ) begin
            wait_cnt <= '0;
        end else if (!input_IF_mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    assign Output_IF_mem_addr = pc;
    assign Output_IF_PC       = pc;
    assign Output_IF_Instru   = instr_q;

endmodule
